// File: rtl/kyber_pkg.sv
// Shared Baby-Kyber constants, coefficient types and the modular reduction helper
// used by the ring multiplier, the coefficient RNG and the key-generation parent.
package kyber_pkg;

  localparam int Q = 17;
  localparam int N = 4;

  // Galois form of x^32 + x^22 + x^2 + x + 1 for a right-shifting register.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef logic [31:0] coeff_t;
  typedef coeff_t poly_t [N];

  // Maps any signed value onto [0,Q-1]; a negative remainder is lifted by Q.
  function automatic int mod_q(input int x);
    int r;
    r = x % Q;
    if (r < 0) r = r + Q;
    return r;
  endfunction

endpackage

// File: rtl/random_number_generator.sv
// Bounded pseudo-random coefficient source: a 32-bit Galois LFSR whose next state
// is folded into [MIN_VALUE, MAX_VALUE] and registered.
module random_number_generator
  import kyber_pkg::*;
#(
  parameter int          MIN_VALUE = -17,
  parameter int          MAX_VALUE = 17,
  parameter logic [31:0] SEED      = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] random_number
);

  localparam logic [31:0] SPAN = 32'(MAX_VALUE - MIN_VALUE + 1);

  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic [31:0] offset;

  always_comb begin
    lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
    offset    = lfsr_next % SPAN;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr          <= SEED;
      random_number <= 32'(MIN_VALUE);
    end else if (enable) begin
      lfsr          <= lfsr_next;
      random_number <= 32'(MIN_VALUE + int'(offset));
    end
  end

endmodule

// File: rtl/polynomial_matrix_multiplication.sv
// Ring multiplier c = a*b in Z_Q[x]/(x^N+1): inputs are reduced mod Q, convolved
// negacyclically in one combinational pass, reduced again and registered.
module polynomial_matrix_multiplication
  import kyber_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  enable,
  input  poly_t polynomial1,
  input  poly_t polynomial2,
  output poly_t polynomial_out
);

  int    a_red   [N];
  int    b_red   [N];
  poly_t product_next;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_red[i] = mod_q(int'(polynomial1[i]));
      b_red[i] = mod_q(int'(polynomial2[i]));
    end
  end

  // Terms with i+j >= N wrap around x^N = -1 and therefore subtract.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      int acc;
      acc = 0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i + j == k)          acc = acc + a_red[i] * b_red[j];
          else if (i + j == k + N) acc = acc - a_red[i] * b_red[j];
        end
      end
      product_next[k] = coeff_t'(mod_q(acc));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      polynomial_out <= '{default: '0};
    end else if (enable) begin
      polynomial_out <= product_next;
    end
  end

endmodule

// File: tb/tb_polynomial_matrix_multiplication.sv
// Self-checking bench: ring product against a polynomial-arithmetic model, plus
// property checks (range, variation, repeatability, hold) on two RNG instances.
module tb_polynomial_matrix_multiplication;
  import kyber_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  enable;
  poly_t a_in;
  poly_t b_in;
  poly_t dut_out;

  logic        rng_rst_n;
  logic        rng_en;
  logic [31:0] rng_a;
  logic [31:0] rng_b;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  polynomial_matrix_multiplication dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .polynomial1    (a_in),
    .polynomial2    (b_in),
    .polynomial_out (dut_out)
  );

  random_number_generator #(.MIN_VALUE(-17), .MAX_VALUE(17), .SEED(32'h1)) rng_wide (
    .clk (clk), .rst_n (rng_rst_n), .enable (rng_en), .random_number (rng_a)
  );

  random_number_generator #(.MIN_VALUE(-1), .MAX_VALUE(17), .SEED(32'h1)) rng_skew (
    .clk (clk), .rst_n (rng_rst_n), .enable (rng_en), .random_number (rng_b)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got %0d (0x%h), expected %0d", name, $signed(actual), actual, $signed(expected));
    end
  endtask

  // Reference: full polynomial product, then fold x^N = -1, then reduce mod Q.
  function automatic longint ref_mod(input longint x);
    return ((x % Q) + Q) % Q;
  endfunction

  function automatic void ring_mul(input poly_t a, input poly_t b, output poly_t c);
    longint ar [N];
    longint br [N];
    longint full [2*N-1];
    for (int i = 0; i < N; i++) begin
      ar[i] = ref_mod(longint'($signed(a[i])));
      br[i] = ref_mod(longint'($signed(b[i])));
    end
    for (int d = 0; d < 2*N-1; d++) full[d] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        full[i+j] += ar[i] * br[j];
    for (int k = 0; k < N; k++) begin
      longint v;
      v = full[k];
      if (k + N < 2*N-1) v -= full[k+N];
      c[k] = 32'(ref_mod(v));
    end
  endfunction

  // Cycle model of the output register, compared on every falling edge.
  poly_t exp_out;
  bit    model_valid = 1'b0;

  always @(posedge clk) begin
    poly_t tmp;
    if (!rst_n) begin
      exp_out     <= '{default: '0};
      model_valid <= 1'b1;
    end else if (enable) begin
      ring_mul(a_in, b_in, tmp);
      exp_out <= tmp;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < N; k++) check($sformatf("stream_out[%0d]", k), dut_out[k], exp_out[k]);
    end
  end

  task automatic drive(input poly_t a, input poly_t b, input logic en, input logic rn);
    @(posedge clk);
    #2;
    a_in   = a;
    b_in   = b;
    enable = en;
    rst_n  = rn;
  endtask

  function automatic coeff_t rand_coeff();
    int sel;
    int specials [6] = '{0, 1, -1, 16, -17, 17};
    sel = int'($urandom_range(0, 2));
    if (sel == 0) return $urandom;
    if (sel == 1) return 32'($signed(int'($urandom_range(0, 80))) - 40);
    return 32'(specials[$urandom_range(0, 5)]);
  endfunction

  task automatic check_poly(input string name, input poly_t actual, input poly_t expected);
    for (int k = 0; k < N; k++) check($sformatf("%s[%0d]", name, k), actual[k], expected[k]);
  endtask

  task automatic rng_reset();
    @(negedge clk);
    rng_rst_n = 1'b0;
    rng_en    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rng_wide_reset", rng_a, 32'hFFFF_FFEF);
    check("rng_skew_reset", rng_b, 32'hFFFF_FFFF);
    rng_rst_n = 1'b1;
  endtask

  logic [31:0] seq_a [2000];
  logic [31:0] seq_b [2000];

  initial begin
    poly_t m, r1, r2, parent, held;
    int bad_a, bad_b, chg_a, chg_b, mis;

    rst_n     = 1'b0;
    enable    = 1'b0;
    a_in      = '{default: '0};
    b_in      = '{default: '0};
    rng_rst_n = 1'b0;
    rng_en    = 1'b0;

    // Pin the model against hand-computed products.
    ring_mul('{32'd11, 32'd16, 32'd16, 32'd6}, '{32'd0, 32'd1, -32'sd1, -32'sd1}, m);
    check_poly("model_v1", m, '{32'd9, 32'd16, 32'd11, 32'd6});
    ring_mul('{32'd3, 32'd6, 32'd4, 32'd9}, '{32'd0, -32'sd1, 32'd0, -32'sd1}, m);
    check_poly("model_v2", m, '{32'd15, 32'd1, 32'd3, 32'd10});
    ring_mul('{32'd0, 32'd0, 32'd0, 32'd1}, '{32'd0, 32'd1, 32'd0, 32'd0}, m);
    check_poly("model_wrap", m, '{32'd16, 32'd0, 32'd0, 32'd0});
    ring_mul('{-32'sd17, -32'sd1, 32'd0, 32'd0}, '{32'd1, 32'd0, 32'd0, 32'd0}, m);
    check_poly("model_neg", m, '{32'd0, 32'd16, 32'd0, 32'd0});

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors observed directly on the DUT.
    drive('{32'd11, 32'd16, 32'd16, 32'd6}, '{32'd0, 32'd1, -32'sd1, -32'sd1}, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    r1 = dut_out;
    check_poly("dut_v1", dut_out, '{32'd9, 32'd16, 32'd11, 32'd6});
    drive('{32'd3, 32'd6, 32'd4, 32'd9}, '{32'd0, -32'sd1, 32'd0, -32'sd1}, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    r2 = dut_out;
    check_poly("dut_v2", dut_out, '{32'd15, 32'd1, 32'd3, 32'd10});
    for (int k = 0; k < N; k++)
      parent[k] = 32'(ref_mod(longint'(r1[k]) + longint'(r2[k]) + ((k == 2) ? 1 : 0)));
    check_poly("parent_sum", parent, '{32'd7, 32'd0, 32'd15, 32'd16});
    drive('{32'd0, 32'd0, 32'd0, 32'd1}, '{32'd0, 32'd1, 32'd0, 32'd0}, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    check_poly("dut_wrap", dut_out, '{32'd16, 32'd0, 32'd0, 32'd0});
    drive('{32'd5, 32'd7, 32'd2, 32'd9}, '{32'd1, 32'd0, 32'd0, 32'd0}, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    check_poly("dut_identity", dut_out, '{32'd5, 32'd7, 32'd2, 32'd9});

    // Enable low with changing inputs: output frozen.
    held = dut_out;
    for (int c = 0; c < 6; c++) begin
      poly_t ra, rb;
      for (int k = 0; k < N; k++) begin ra[k] = rand_coeff(); rb[k] = rand_coeff(); end
      drive(ra, rb, 1'b0, 1'b1);
    end
    @(posedge clk); @(negedge clk);
    check_poly("dut_hold", dut_out, held);

    // Randomized stream with idle cycles and occasional single-cycle resets.
    for (int c = 0; c < 600; c++) begin
      poly_t ra, rb;
      for (int k = 0; k < N; k++) begin ra[k] = rand_coeff(); rb[k] = rand_coeff(); end
      drive(ra, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) != 0));
    end
    drive(a_in, b_in, 1'b1, 1'b1);

    // RNG: range, variation, repeatability after re-reset, and hold.
    rng_reset();
    bad_a = 0; bad_b = 0; chg_a = 0; chg_b = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); @(negedge clk);
      seq_a[i] = rng_a;
      seq_b[i] = rng_b;
      if ($signed(rng_a) < -17 || $signed(rng_a) > 17) bad_a++;
      if ($signed(rng_b) < -1  || $signed(rng_b) > 17) bad_b++;
      if (i > 0 && seq_a[i] != seq_a[i-1]) chg_a++;
      if (i > 0 && seq_b[i] != seq_b[i-1]) chg_b++;
    end
    check("rng_wide_range_violations", 32'(bad_a), 32'd0);
    check("rng_skew_range_violations", 32'(bad_b), 32'd0);
    check("rng_wide_varies", 32'(chg_a > 100), 32'd1);
    check("rng_skew_varies", 32'(chg_b > 100), 32'd1);

    rng_reset();
    mis = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        rng_en = 1'b0;
        for (int h = 0; h < 5; h++) begin
          @(posedge clk); @(negedge clk);
          check("rng_wide_hold", rng_a, seq_a[999]);
          check("rng_skew_hold", rng_b, seq_b[999]);
        end
        rng_en = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      if (rng_a !== seq_a[i] || rng_b !== seq_b[i]) mis++;
    end
    check("rng_repeat_mismatches", 32'(mis), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
